// File: rtl/collapse_read_initiator.sv
// Host-side initiator for a read-once, basis-gated collapse cell: provisions, issues the single
// measurement, confirms collapse via fuse_fire. Optional pad check: `define COLLAPSE_RD_PAD_CHECK_EN.
module collapse_read_initiator #(
    parameter int WIDTH        = 8,
    parameter int BASIS_W      = 2,
    parameter int FIRE_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [BASIS_W-1:0] cmd_basis,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [2:0]         rsp_status,
    output logic               cell_init,
    output logic [WIDTH-1:0]   cell_value_in,
    output logic               cell_read,
    output logic [BASIS_W-1:0] cell_read_basis,
    input  logic [WIDTH-1:0]   cell_value_out,
    input  logic               cell_output_enable,
    input  logic               cell_pad_enable,
    input  logic               cell_fuse_fire,
    output logic               live,
    output logic               spent
);

    typedef enum logic [2:0] {
        IDLE,
        INIT_PULSE,
        STROBE,
        WAIT_FIRE,
        RESP
    } state_e;

    localparam logic [2:0] ST_OK_PROV    = 3'd0;
    localparam logic [2:0] ST_OK_TRUE    = 3'd1;
    localparam logic [2:0] ST_OK_OBF     = 3'd2;
    localparam logic [2:0] ST_ERR_SPENT  = 3'd3;
    localparam logic [2:0] ST_ERR_NOFIRE = 3'd4;
    localparam logic [2:0] ST_ERR_UNPROV = 3'd5;
    localparam logic [7:0] CNT_LAST      = 8'(FIRE_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [BASIS_W-1:0] basis_q, basis_d;
    logic               match_q, match_d;
    logic [2:0]         status_q, status_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               live_q, live_d;
    logic               spent_q, spent_d;
    logic [2:0]         fired_status;

`ifdef COLLAPSE_RD_PAD_CHECK_EN
    localparam logic [2:0] ST_ERR_PAD = 3'd6;
    logic pad_err_q, pad_err_d;

    always_comb begin
        fired_status = ST_OK_OBF;
        if (match_q)
            fired_status = ST_OK_TRUE;
        else if (pad_err_q)
            fired_status = ST_ERR_PAD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pad_err_q <= 1'b0;
        else       pad_err_q <= pad_err_d;
    end
`else
    logic pad_unused;
    assign pad_unused   = cell_pad_enable;
    assign fired_status = match_q ? ST_OK_TRUE : ST_OK_OBF;
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        basis_d  = basis_q;
        match_d  = match_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        live_d   = live_q;
        spent_d  = spent_q;
`ifdef COLLAPSE_RD_PAD_CHECK_EN
        pad_err_d = pad_err_q;
`endif
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        rsp_status      = '0;
        cell_init       = 1'b0;
        cell_value_in   = '0;
        cell_read       = 1'b0;
        cell_read_basis = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    data_d  = cmd_op ? '0 : cmd_data;
                    basis_d = cmd_basis;
                    match_d = 1'b0;
`ifdef COLLAPSE_RD_PAD_CHECK_EN
                    pad_err_d = 1'b0;
`endif
                    // The kill latch is permanent: once spent, neither op may touch the cell.
                    if (spent_q) begin
                        status_d = ST_ERR_SPENT;
                        state_d  = RESP;
                    end else if (!cmd_op) begin
                        state_d = INIT_PULSE;
                    end else if (!live_q) begin
                        status_d = ST_ERR_UNPROV;
                        state_d  = RESP;
                    end else begin
                        state_d = STROBE;
                    end
                end
            end
            INIT_PULSE: begin
                cell_init     = 1'b1;
                cell_value_in = data_q;
                live_d        = 1'b1;
                data_d        = '0;
                status_d      = ST_OK_PROV;
                state_d       = RESP;
            end
            STROBE: begin
                cell_read       = 1'b1;
                cell_read_basis = basis_q;
                spent_d         = 1'b1;
                live_d          = 1'b0;
                cnt_d           = '0;
                data_d          = '0;
                match_d         = 1'b0;
                // Only a logically enabled output is real data; obfuscation never enters a flop.
`ifdef COLLAPSE_RD_PAD_CHECK_EN
                if (cell_output_enable && cell_pad_enable) begin
                    data_d  = cell_value_out;
                    match_d = 1'b1;
                end else begin
                    pad_err_d = cell_output_enable;
                end
`else
                if (cell_output_enable) begin
                    data_d  = cell_value_out;
                    match_d = 1'b1;
                end
`endif
                state_d = WAIT_FIRE;
            end
            WAIT_FIRE: begin
                if (cell_fuse_fire) begin
                    status_d = fired_status;
                    if (fired_status != ST_OK_TRUE)
                        data_d = '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    status_d = ST_ERR_NOFIRE;
                    data_d   = '0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_status = status_q;
                rsp_data   = (status_q == ST_OK_TRUE) ? data_q : '0;
                if (rsp_ready) begin
                    data_d  = '0;
                    basis_d = '0;
                    match_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fire we did not ask for means the cell collapsed anyway (tamper).
        if (cell_fuse_fire && state_q != WAIT_FIRE) begin
            spent_d = 1'b1;
            live_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            basis_q  <= '0;
            match_q  <= 1'b0;
            status_q <= '0;
            cnt_q    <= '0;
            live_q   <= 1'b0;
            spent_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            basis_q  <= basis_d;
            match_q  <= match_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            live_q   <= live_d;
            spent_q  <= spent_d;
        end
    end

    assign live  = live_q;
    assign spent = spent_q;

endmodule

// File: tb/tb_collapse_read_initiator.sv
// Self-checking bench for collapse_read_initiator: behavioural cell model plus a rule-level
// reference of liveness/spent/status, directed scenarios and randomized episodes.
module tb_collapse_read_initiator;
    localparam int W  = 8;
    localparam int BW = 2;
    localparam int FT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [W-1:0]  cmd_data = '0;
    logic [BW-1:0] cmd_basis = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic [2:0]    rsp_status;
    logic          cell_init;
    logic [W-1:0]  cell_value_in;
    logic          cell_read;
    logic [BW-1:0] cell_read_basis;
    logic [W-1:0]  cell_val = '0;
    logic          cell_oe = 1'b0;
    logic          cell_pad = 1'b0;
    logic          cell_fuse_fire = 1'b0;
    logic          live;
    logic          spent;

    int            n_checks = 0;
    int            n_pass = 0;
    int            n_reads = 0;
    int            n_inits = 0;
    int            fire_delay = 0;
    int            fire_cd = 0;
    bit            stray_req = 1'b0;
    logic [W-1:0]  last_init_val = '0;
    logic [BW-1:0] last_read_basis = '0;

    always #5 clk = ~clk;

    collapse_read_initiator #(.WIDTH(W), .BASIS_W(BW), .FIRE_TIMEOUT(FT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_basis(cmd_basis),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .cell_init(cell_init), .cell_value_in(cell_value_in),
        .cell_read(cell_read), .cell_read_basis(cell_read_basis),
        .cell_value_out(cell_val), .cell_output_enable(cell_oe), .cell_pad_enable(cell_pad),
        .cell_fuse_fire(cell_fuse_fire), .live(live), .spent(spent)
    );

    // Cell model: fires fire_delay cycles after the read strobe (0 = never), one-cycle pulse.
    always @(negedge clk) begin
        cell_fuse_fire = stray_req;
        if (fire_cd > 0) begin
            fire_cd = fire_cd - 1;
            if (fire_cd == 0) cell_fuse_fire = 1'b1;
        end
        if (cell_read) begin
            n_reads = n_reads + 1;
            last_read_basis = cell_read_basis;
            if (fire_delay > 0) fire_cd = fire_delay;
        end
        if (cell_init) begin
            n_inits = n_inits + 1;
            last_init_val = cell_value_in;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        fire_delay = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one command, wait (bounded) for the response; lat = edges from accept to rsp_valid.
    task automatic do_cmd(input bit op, input logic [W-1:0] d, input logic [BW-1:0] b,
                          output logic [2:0] st, output logic [W-1:0] dat, output int lat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_basis = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_data = '0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) lat = -1;
        st = rsp_status;
        dat = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_status, cell_init, cell_value_in, cell_read, cell_read_basis, live, spent} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got rdy=%b vld=%b live=%b spent=%b want rdy=1 others 0", cmd_ready, rsp_valid, live, spent);
        else n_pass++;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, live, spent} !== 4'b1000)
            $display("FAIL reset_release_idle: got %b want 1000", {cmd_ready, rsp_valid, live, spent});
        else n_pass++;
    endtask

    task automatic test_match();
        logic [2:0] st; logic [W-1:0] dat; int lat, r0, i0;
        do_reset();
        r0 = n_reads; i0 = n_inits;
        do_cmd(1'b0, 8'h3C, 2'd0, st, dat, lat);
        n_checks++; if (st !== 3'd0 || dat !== 8'h00 || lat != 2) $display("FAIL prov_rsp: got st=%0d dat=%h lat=%0d want st=0 dat=00 lat=2", st, dat, lat); else n_pass++;
        n_checks++; if (n_inits - i0 != 1 || last_init_val !== 8'h3C) $display("FAIL prov_init_pulse: got n=%0d val=%h want n=1 val=3c", n_inits - i0, last_init_val); else n_pass++;
        n_checks++; if ({live, spent} !== 2'b10) $display("FAIL prov_live: got %b want 10", {live, spent}); else n_pass++;
        cell_oe = 1'b1; cell_pad = 1'b1; cell_val = 8'h3C; fire_delay = 1;
        do_cmd(1'b1, 8'h00, 2'd1, st, dat, lat);
        n_checks++; if (st !== 3'd1 || dat !== 8'h3C) $display("FAIL match_rsp: got st=%0d dat=%h want st=1 dat=3c", st, dat); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL match_latency: got %0d want 3", lat); else n_pass++;
        n_checks++; if (n_reads - r0 != 1 || last_read_basis !== 2'd1) $display("FAIL match_read_pulse: got n=%0d basis=%0d want n=1 basis=1", n_reads - r0, last_read_basis); else n_pass++;
        n_checks++; if ({live, spent} !== 2'b01) $display("FAIL match_spent: got %b want 01", {live, spent}); else n_pass++;
    endtask

    task automatic test_wrong_basis_then_spent();
        logic [2:0] st; logic [W-1:0] dat; int lat, r0, i0;
        do_reset();
        do_cmd(1'b0, 8'h3C, 2'd0, st, dat, lat);
        cell_oe = 1'b0; cell_pad = 1'b0; cell_val = 8'h9A; fire_delay = 1;
        do_cmd(1'b1, 8'h00, 2'd2, st, dat, lat);
        n_checks++; if (st !== 3'd2 || dat !== 8'h00) $display("FAIL obf_rsp: got st=%0d dat=%h want st=2 dat=00", st, dat); else n_pass++;
        r0 = n_reads; i0 = n_inits;
        do_cmd(1'b1, 8'h00, 2'd1, st, dat, lat);
        n_checks++; if (st !== 3'd3 || lat != 1) $display("FAIL spent_measure: got st=%0d lat=%0d want st=3 lat=1", st, lat); else n_pass++;
        do_cmd(1'b0, 8'h55, 2'd0, st, dat, lat);
        n_checks++; if (st !== 3'd3 || dat !== 8'h00) $display("FAIL spent_provision: got st=%0d dat=%h want st=3 dat=00", st, dat); else n_pass++;
        n_checks++; if (n_reads != r0 || n_inits != i0) $display("FAIL spent_no_strobe: got reads+%0d inits+%0d want 0 0", n_reads - r0, n_inits - i0); else n_pass++;
    endtask

    task automatic test_unprov_and_timeout();
        logic [2:0] st; logic [W-1:0] dat; int lat, r0;
        do_reset();
        r0 = n_reads;
        do_cmd(1'b1, 8'h00, 2'd1, st, dat, lat);
        n_checks++; if (st !== 3'd5 || n_reads != r0) $display("FAIL unprov: got st=%0d reads+%0d want st=5 reads+0", st, n_reads - r0); else n_pass++;
        do_cmd(1'b0, 8'hA5, 2'd0, st, dat, lat);
        cell_oe = 1'b1; cell_pad = 1'b1; cell_val = 8'hA5; fire_delay = 0;
        do_cmd(1'b1, 8'h00, 2'd1, st, dat, lat);
        n_checks++; if (st !== 3'd4 || dat !== 8'h00) $display("FAIL nofire_rsp: got st=%0d dat=%h want st=4 dat=00", st, dat); else n_pass++;
        n_checks++; if (lat != FT + 2) $display("FAIL nofire_latency: got %0d want %0d", lat, FT + 2); else n_pass++;
        // fire on the last window cycle still wins
        do_reset();
        do_cmd(1'b0, 8'hA5, 2'd0, st, dat, lat);
        fire_delay = FT;
        do_cmd(1'b1, 8'h00, 2'd1, st, dat, lat);
        n_checks++; if (st !== 3'd1 || dat !== 8'hA5 || lat != FT + 2) $display("FAIL late_fire_wins: got st=%0d dat=%h lat=%0d want st=1 dat=a5 lat=%0d", st, dat, lat, FT + 2); else n_pass++;
    endtask

    task automatic test_hold_and_reset();
        logic [2:0] st, s0; logic [W-1:0] dat, d0; int lat, n;
        do_reset();
        do_cmd(1'b0, 8'h11, 2'd0, st, dat, lat);
        cell_oe = 1'b1; cell_pad = 1'b1; cell_val = 8'h11; fire_delay = 1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_basis = 2'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        s0 = rsp_status; d0 = rsp_data;
        n_checks++; if (rsp_valid !== 1'b1 || s0 !== 3'd1 || d0 !== 8'h11) $display("FAIL hold_first: got vld=%b st=%0d dat=%h want vld=1 st=1 dat=11", rsp_valid, s0, d0); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({rsp_valid, cmd_ready, rsp_status, rsp_data} !== {1'b1, 1'b0, 3'd1, 8'h11})
                $display("FAIL hold_stable_%0d: got vld=%b rdy=%b st=%0d dat=%h want 1 0 1 11", i, rsp_valid, cmd_ready, rsp_status, rsp_data);
            else n_pass++;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_status, cell_init, cell_read, live, spent} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_mid_resp: got rdy=%b vld=%b dat=%h st=%0d live=%b spent=%b", cmd_ready, rsp_valid, rsp_data, rsp_status, live, spent);
        else n_pass++;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL resp_dropped: got vld=%b rdy=%b want 0 1", rsp_valid, cmd_ready); else n_pass++;
    endtask

    task automatic test_stray_fire();
        logic [2:0] st; logic [W-1:0] dat; int lat, r0; bit saw_vld;
        do_reset();
        do_cmd(1'b0, 8'h77, 2'd0, st, dat, lat);
        saw_vld = 1'b0;
        @(posedge clk); #1; stray_req = 1'b1;
        @(posedge clk); #1; stray_req = 1'b0; saw_vld = saw_vld | rsp_valid;
        @(posedge clk); #1; saw_vld = saw_vld | rsp_valid;
        n_checks++; if ({live, spent, saw_vld} !== 3'b010) $display("FAIL stray_fire: got live=%b spent=%b vld=%b want 0 1 0", live, spent, saw_vld); else n_pass++;
        r0 = n_reads;
        do_cmd(1'b1, 8'h00, 2'd0, st, dat, lat);
        n_checks++; if (st !== 3'd3 || n_reads != r0) $display("FAIL stray_then_measure: got st=%0d reads+%0d want st=3 reads+0", st, n_reads - r0); else n_pass++;
    endtask

    task automatic test_pad();
        logic [2:0] st, e_st; logic [W-1:0] dat, e_dat; int lat;
`ifdef COLLAPSE_RD_PAD_CHECK_EN
        e_st = 3'd6; e_dat = 8'h00;
`else
        e_st = 3'd1; e_dat = 8'h5A;
`endif
        do_reset();
        do_cmd(1'b0, 8'h5A, 2'd0, st, dat, lat);
        cell_oe = 1'b1; cell_pad = 1'b0; cell_val = 8'h5A; fire_delay = 2;
        do_cmd(1'b1, 8'h00, 2'd0, st, dat, lat);
        n_checks++; if (st !== e_st || dat !== e_dat || lat != 4) $display("FAIL pad_rsp: got st=%0d dat=%h lat=%0d want st=%0d dat=%h lat=4", st, dat, lat, e_st, e_dat); else n_pass++;
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 25; ep++) begin
            logic m_live, m_spent; logic [W-1:0] m_secret; logic [BW-1:0] m_sbasis;
            do_reset();
            m_live = 1'b0; m_spent = 1'b0; m_secret = '0; m_sbasis = BW'($urandom);
            for (int k = 0; k < 4; k++) begin
                bit op, match; logic [W-1:0] d, dat, e_dat; logic [BW-1:0] b; logic [2:0] st, e_st;
                int fd, lat, e_lat, e_rd, e_in, r0, i0;
                op = 1'($urandom_range(0, 1));
                d = W'($urandom);
                b = ($urandom_range(0, 1) != 0) ? m_sbasis : BW'($urandom);
                match = (b == m_sbasis);
                fd = $urandom_range(0, FT + 1);
                cell_oe = match; cell_pad = match;
                cell_val = match ? m_secret : W'($urandom);
                fire_delay = fd;
                e_rd = 0; e_in = 0; e_dat = '0;
                if (m_spent) begin
                    e_st = 3'd3; e_lat = 1;
                end else if (!op) begin
                    e_st = 3'd0; e_lat = 2; e_in = 1; m_live = 1'b1; m_secret = d;
                end else if (!m_live) begin
                    e_st = 3'd5; e_lat = 1;
                end else begin
                    e_rd = 1; m_spent = 1'b1; m_live = 1'b0;
                    if (fd >= 1 && fd <= FT) begin
                        e_st = match ? 3'd1 : 3'd2; e_lat = 2 + fd; e_dat = match ? m_secret : '0;
                    end else begin
                        e_st = 3'd4; e_lat = FT + 2;
                    end
                end
                r0 = n_reads; i0 = n_inits;
                do_cmd(op, d, b, st, dat, lat);
                n_checks++; if (st !== e_st || dat !== e_dat) $display("FAIL rand_rsp ep%0d k%0d: got st=%0d dat=%h want st=%0d dat=%h", ep, k, st, dat, e_st, e_dat); else n_pass++;
                n_checks++; if (lat != e_lat) $display("FAIL rand_latency ep%0d k%0d: got %0d want %0d", ep, k, lat, e_lat); else n_pass++;
                n_checks++; if (n_reads - r0 != e_rd || n_inits - i0 != e_in) $display("FAIL rand_strobes ep%0d k%0d: got rd=%0d in=%0d want rd=%0d in=%0d", ep, k, n_reads - r0, n_inits - i0, e_rd, e_in); else n_pass++;
                n_checks++; if ({live, spent} !== {m_live, m_spent}) $display("FAIL rand_flags ep%0d k%0d: got %b want %b", ep, k, {live, spent}, {m_live, m_spent}); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_wrong_basis_then_spent();
        test_unprov_and_timeout();
        test_hold_and_reset();
        test_stray_fire();
        test_pad();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/collapse_read_initiator.md
Name: collapse_read_initiator

Overview:
- Host-side initiator for a read-once, basis-gated collapse cell.
- Accepts provision/measure commands over a valid/ready host interface and drives the cell's init/read/basis strobes.
- Captures the same-cycle cell output, confirms collapse via the cell's fuse_fire pulse, and returns a status-coded response.
- Tracks cell liveness so that the single measurement is never wasted on an unprovisioned or already-spent cell.

Parameters:
- WIDTH, 8, data width of the secret value.
- BASIS_W, 2, width of the basis field.
- FIRE_TIMEOUT, 4, cycles to wait for cell_fuse_fire after the read strobe (range 1..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  initiator can accept a command
- cmd_op  in  1  0=provision, 1=measure
- cmd_data  in  WIDTH  provisioning value
- cmd_basis  in  BASIS_W  measurement basis guess
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  WIDTH  recovered secret (zero unless status OK_TRUE)
- rsp_status  out  3  result code
- cell_init  out  1  one-cycle init strobe to cell
- cell_value_in  out  WIDTH  provisioning value to cell
- cell_read  out  1  one-cycle read strobe to cell
- cell_read_basis  out  BASIS_W  basis to cell
- cell_value_out  in  WIDTH  cell data (valid same cycle as cell_read)
- cell_output_enable  in  1  cell logical OE
- cell_pad_enable  in  1  cell physical OE
- cell_fuse_fire  in  1  cell collapse pulse
- live  out  1  cell provisioned and not yet measured
- spent  out  1  sticky: a measurement has been issued

Behaviour:
- Reset, clk: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - All outputs 0, except cmd_ready=1.
  - FSM in IDLE; live=0, spent=0; timeout counter 0.
- Status codes:
  - 0 OK_PROV
  - 1 OK_TRUE (basis matched, secret captured)
  - 2 OK_OBF (collapsed, wrong basis)
  - 3 ERR_SPENT
  - 4 ERR_NOFIRE
  - 5 ERR_UNPROV
  - 6 ERR_PAD (optional feature only)
- States: IDLE, INIT_PULSE, STROBE, WAIT_FIRE, RESP.
- IDLE:
  - cmd_ready=1; a command is accepted on cmd_valid&&cmd_ready; cmd_data and cmd_basis are registered.
  - Provision && !spent -> INIT_PULSE.
  - Provision && spent -> RESP with ERR_SPENT; no cell strobe. The cell's kill latch is permanent, so re-provisioning is refused.
  - Measure && spent -> RESP with ERR_SPENT; no strobe.
  - Measure && !live -> RESP with ERR_UNPROV; no strobe.
  - Measure && live -> STROBE.
- INIT_PULSE (1 cycle):
  - cell_init=1, cell_value_in=registered data.
  - Next: live<=1 -> RESP with OK_PROV.
- STROBE (exactly 1 cycle):
  - cell_read=1, cell_read_basis=registered basis.
  - On this edge: spent<=1, live<=0.
  - If cell_output_enable=1, capture cell_value_out into the data register and set the match flag; otherwise the data register is 0.
  - -> WAIT_FIRE with counter=0.
- WAIT_FIRE:
  - cell_fuse_fire=1 -> RESP; status OK_TRUE if the match flag is set, else OK_OBF.
  - Otherwise the counter increments. When the counter reaches FIRE_TIMEOUT-1 with no fire -> RESP with ERR_NOFIRE and rsp_data forced 0, even if the match flag is set.
  - A fire seen on the same cycle the counter reaches FIRE_TIMEOUT-1 wins (OK_*).
- RESP:
  - rsp_valid=1; rsp_data and rsp_status held stable until rsp_ready.
  - On the rsp_valid&&rsp_ready edge -> IDLE, data register cleared to 0.
  - cmd_ready=0 in every state except IDLE.
- Data hygiene:
  - rsp_data is nonzero only with OK_TRUE.
  - Obfuscation data from the cell is never registered.
- Stray cell_fuse_fire outside WAIT_FIRE: spent<=1, live<=0 (tamper-induced collapse); no response is generated.
- Latency, measure: accept -> cell_read 1 cycle later -> rsp_valid 1 cycle after the fire is seen (3 cycles minimum with the cell's registered fire).
- Reset mid-operation: immediate return to the reset values; any in-flight response is dropped.

Optional Feature:
- Macro: COLLAPSE_RD_PAD_CHECK_EN.
- Defined:
  - OK_TRUE additionally requires cell_pad_enable=1 in STROBE.
  - If cell_output_enable=1 but cell_pad_enable=0, the data is discarded and status is ERR_PAD (6), still only after fire/timeout resolution.
  - ERR_NOFIRE takes precedence over ERR_PAD.
- Not defined: cell_pad_enable is ignored and code 6 is never produced.

Test Plan:
- Provision 0x3C, then measure with the matching basis; cell returns 0x3C with OE=1 and fire 1 cycle after the strobe -> rsp OK_TRUE, data 0x3C; live=0, spent=1; exactly one cell_read pulse.
- Provision 0x3C, then measure with the wrong basis (OE=0, value 0x9A) -> OK_OBF, data 0x00.
- After a spent measure, issue measure and then provision -> both ERR_SPENT; cell_read and cell_init never pulse.
- Measure from reset without provisioning -> ERR_UNPROV, no strobe; cell never fires with FIRE_TIMEOUT=4 -> ERR_NOFIRE exactly 4 cycles after the strobe, data 0x00.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, data and status stable; cmd_ready=0 throughout; assert reset mid-RESP -> all outputs 0, cmd_ready=1.
- With COLLAPSE_RD_PAD_CHECK_EN: OE=1, pad_enable=0, fire seen -> ERR_PAD, data 0x00.
